// File: rtl/ladybird_uart_loader.sv
// rtl/ladybird_uart_loader.sv - UART byte stream to IRAM write loader that releases the core once the image is in
module ladybird_uart_loader #(
    parameter int XLEN      = 32,
    parameter int BASE_ADDR = 0,
    parameter int MAX_WORDS = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    output logic              bus_req,
    input  logic              bus_gnt,
    output logic [XLEN-1:0]   bus_addr,
    output logic [XLEN/8-1:0] bus_wstrb,
    output logic [XLEN-1:0]   bus_wdata,
    output logic              core_run,
    output logic              done,
    output logic [1:0]        err
);
    localparam int IDX_W = $clog2(MAX_WORDS) + 1;

    typedef enum logic [2:0] {S_HDR, S_DATA, S_WR, S_DONE, S_ERR} state_t;

    state_t            state;
    logic [1:0]        byte_cnt;
    logic [XLEN-1:0]   shift_q;
    logic [IDX_W-1:0]  n_words;
    logic [IDX_W-1:0]  idx;
    logic              byte_in;
    logic [XLEN-1:0]   word_next;

    // Little-endian assembly: each new byte enters at the top and shifts down.
    assign byte_in   = rx_valid && rx_ready;
    assign word_next = {rx_data, shift_q[XLEN-1:8]};
    assign bus_wstrb = {(XLEN/8){bus_req}};

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_HDR;
            byte_cnt <= 2'd0;
            shift_q  <= '0;
            n_words  <= '0;
            idx      <= '0;
            rx_ready <= 1'b1;
            bus_req  <= 1'b0;
            bus_addr <= '0;
            bus_wdata <= '0;
            core_run <= 1'b0;
            done     <= 1'b0;
            err      <= 2'b00;
        end else begin
            if (rx_valid && !rx_ready) begin
                err[0] <= 1'b1;
            end
            case (state)
                S_HDR: begin
                    if (byte_in) begin
                        shift_q  <= word_next;
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            if (word_next == '0) begin
                                state <= S_DONE;
                                done  <= 1'b1;
                            end else if (word_next > XLEN'(MAX_WORDS)) begin
                                state  <= S_ERR;
                                err[1] <= 1'b1;
                            end else begin
                                n_words <= word_next[IDX_W-1:0];
                                idx     <= '0;
                                state   <= S_DATA;
                            end
                        end
                    end
                end
                S_DATA: begin
                    if (byte_in) begin
                        shift_q  <= word_next;
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            bus_wdata <= word_next;
                            bus_addr  <= XLEN'(BASE_ADDR) + (XLEN'(idx) << 2);
                            bus_req   <= 1'b1;
                            rx_ready  <= 1'b0;
                            state     <= S_WR;
                        end
                    end
                end
                S_WR: begin
                    if (bus_gnt) begin
                        bus_req  <= 1'b0;
                        rx_ready <= 1'b1;
                        idx      <= idx + 1'b1;
                        if (idx + 1'b1 == n_words) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= S_DATA;
                        end
                    end
                end
                S_DONE: begin
                    core_run <= 1'b1;
                end
                S_ERR: begin
                    core_run <= 1'b0;
                end
                default: state <= S_HDR;
            endcase
        end
    end
endmodule

// File: tb/tb_ladybird_uart_loader.sv
// tb/tb_ladybird_uart_loader.sv - directed scoreboard bench for ladybird_uart_loader
module tb_ladybird_uart_loader;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_ready;
    logic        bus_req;
    logic        bus_gnt;
    logic [31:0] bus_addr;
    logic [3:0]  bus_wstrb;
    logic [31:0] bus_wdata;
    logic        core_run;
    logic        done;
    logic [1:0]  err;

    int total = 0;
    int bad = 0;
    int wr_cnt = 0;

    // gnt_mode: 0 = gnt_force, 1 = tied high, 2 = delayed responder
    int   gnt_mode = 1;
    logic gnt_force = 1'b0;
    logic dly_gnt = 1'b0;
    int   wait_cnt = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;
    wr_t exp_q[$];

    logic        prev_req = 1'b0;
    logic        prev_gnt = 1'b0;
    logic [31:0] prev_addr = '0;
    logic [31:0] prev_data = '0;

    assign bus_gnt = (gnt_mode == 1) ? 1'b1 : (gnt_mode == 2) ? dly_gnt : gnt_force;

    ladybird_uart_loader #(.XLEN(32), .BASE_ADDR(0), .MAX_WORDS(8)) dut (
        .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
        .bus_req(bus_req), .bus_gnt(bus_gnt), .bus_addr(bus_addr), .bus_wstrb(bus_wstrb),
        .bus_wdata(bus_wdata), .core_run(core_run), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (bus_req) begin
            if (wait_cnt == 3) begin
                dly_gnt = 1'b1;
                wait_cnt = 0;
            end else begin
                dly_gnt = 1'b0;
                wait_cnt++;
            end
        end else begin
            dly_gnt = 1'b0;
            wait_cnt = 0;
        end
    end

    // Write monitor: a write completes on the posedge following a negedge with req && gnt.
    always @(negedge clk) begin
        if (bus_req && !rst) begin
            if (prev_req && !prev_gnt) begin
                check("hold_addr", bus_addr, prev_addr);
                check("hold_wdata", bus_wdata, prev_data);
            end
            if (bus_gnt) begin
                wr_cnt++;
                check("sb_pending", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    wr_t e;
                    e = exp_q.pop_front();
                    check("wr_addr", bus_addr, e.addr);
                    check("wr_wdata", bus_wdata, e.data);
                    check("wr_wstrb", 32'(bus_wstrb), 32'hf);
                end
            end
        end
        prev_req  = bus_req && !rst;
        prev_gnt  = bus_gnt;
        prev_addr = bus_addr;
        prev_data = bus_wdata;
    end

    task automatic do_reset();
        rst = 1'b1;
        rx_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        while (!rx_ready && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n == 100) check("rx_ready_wait", 32'(rx_ready), 32'd1);
        rx_data = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_raw(input logic [7:0] b);
        rx_data = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8]);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 300; i++) begin
            if (done) break;
            @(posedge clk);
            #1;
        end
        check("done", 32'(done), 32'd1);
    endtask

    initial begin
        int w0;
        logic [31:0] w;

        // 1: reset values
        gnt_mode = 1;
        do_reset();
        check("rst_rx_ready", 32'(rx_ready), 32'd1);
        check("rst_bus_req", 32'(bus_req), 32'd0);
        check("rst_core_run", 32'(core_run), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);

        // 2: one-word image, gnt tied high
        w0 = wr_cnt;
        exp_q.push_back('{addr: 32'h0, data: 32'hfff00093});
        send_word(32'd1);
        send_byte(8'h93); send_byte(8'h00); send_byte(8'hf0); send_byte(8'hff);
        check("t2_req_latency", 32'(bus_req), 32'd1);
        check("t2_wdata", bus_wdata, 32'hfff00093);
        @(posedge clk); #1;
        check("t2_done", 32'(done), 32'd1);
        check("t2_core_run_early", 32'(core_run), 32'd0);
        @(posedge clk); #1;
        check("t2_core_run", 32'(core_run), 32'd1);
        send_byte(8'h5a);
        @(posedge clk); #1;
        check("t2_writes", 32'(wr_cnt - w0), 32'd1);
        check("t2_err", 32'(err), 32'd0);

        // 3: five words, delayed grant
        gnt_mode = 2;
        do_reset();
        w0 = wr_cnt;
        send_word(32'd5);
        for (int i = 0; i < 5; i++) begin
            w = $urandom;
            exp_q.push_back('{addr: 32'(4 * i), data: w});
            send_word(w);
        end
        wait_done();
        @(posedge clk); #1;
        check("t3_writes", 32'(wr_cnt - w0), 32'd5);
        check("t3_sb_empty", 32'(exp_q.size()), 32'd0);
        check("t3_core_run", 32'(core_run), 32'd1);
        check("t3_err", 32'(err), 32'd0);

        // 4: header too large
        gnt_mode = 1;
        do_reset();
        w0 = wr_cnt;
        send_word(32'd9);
        check("t4_err", 32'(err), 32'h2);
        send_byte(8'h11); send_byte(8'h22);
        repeat (5) @(posedge clk);
        #1;
        check("t4_bus_req", 32'(bus_req), 32'd0);
        check("t4_core_run", 32'(core_run), 32'd0);
        check("t4_done", 32'(done), 32'd0);
        check("t4_err_hold", 32'(err), 32'h2);
        check("t4_writes", 32'(wr_cnt - w0), 32'd0);

        // 5: overrun while waiting for grant
        gnt_mode = 0;
        gnt_force = 1'b0;
        do_reset();
        w0 = wr_cnt;
        exp_q.push_back('{addr: 32'h0, data: 32'hdeadbeef});
        send_word(32'd1);
        send_word(32'hdeadbeef);
        check("t5_req", 32'(bus_req), 32'd1);
        send_raw(8'h55);
        check("t5_overrun", 32'(err), 32'h1);
        repeat (2) @(posedge clk);
        #1;
        check("t5_wdata_held", bus_wdata, 32'hdeadbeef);
        gnt_force = 1'b1;
        wait_done();
        gnt_force = 1'b0;
        check("t5_writes", 32'(wr_cnt - w0), 32'd1);
        check("t5_err", 32'(err), 32'h1);

        // 6: reset mid-word, then clean image
        gnt_mode = 1;
        do_reset();
        send_word(32'd1);
        send_byte(8'haa); send_byte(8'hbb);
        do_reset();
        check("t6_rst_err", 32'(err), 32'd0);
        check("t6_rst_req", 32'(bus_req), 32'd0);
        w0 = wr_cnt;
        exp_q.push_back('{addr: 32'h0, data: 32'h12345678});
        send_word(32'd1);
        send_word(32'h12345678);
        wait_done();
        @(posedge clk); #1;
        check("t6_writes", 32'(wr_cnt - w0), 32'd1);
        check("t6_sb_empty", 32'(exp_q.size()), 32'd0);
        check("t6_core_run", 32'(core_run), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
